fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/redirect_latch.sv | 53 +++++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared IFU definitions: fetch state encoding, reset vector default, word alignment helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } ifu_state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'hbfc0_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds the redirect that arrives while a fetch is in flight, plus the kill flag for that fetch.
// Latency: captured target visible the cycle after capture; merged target is combinational.
// Backpressure: none; an exception always overwrites, a branch never displaces a pending exception.
module redirect_latch
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        kill,
  output logic [31:0] redir_target
);

  logic        pend_valid;
  logic        pend_exc;
  logic [31:0] pend_target;

  // Current request merged with whatever is already pending, exception first.
  always_comb begin
    redir_target = pend_target;
    if (exc_valid) begin
      redir_target = word_align(exc_target);
    end else if (pend_valid && pend_exc) begin
      redir_target = pend_target;
    end else if (br_valid) begin
      redir_target = word_align(br_target);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kill        <= 1'b0;
      pend_valid  <= 1'b0;
      pend_exc    <= 1'b0;
      pend_target <= 32'h0;
    end else if (clear) begin
      kill       <= 1'b0;
      pend_valid <= 1'b0;
      pend_exc   <= 1'b0;
    end else if (capture && (exc_valid || br_valid)) begin
      kill        <= 1'b1;
      pend_valid  <= 1'b1;
      pend_exc    <= exc_valid || (pend_valid && pend_exc);
      pend_target <= redir_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like read, redirect handling, single fetched entry.
// Latency: entry valid the cycle after inst_data_ok; inst_req/inst_addr decode directly from state and pc.
// Backpressure: stall holds the fetched entry and parks the fetcher in IDLE after the next completion.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] pc
);

  ifu_state_t  state;
  ifu_state_t  state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] redir_target;
  logic        redir;
  logic        kill;
  logic        capture;
  logic        clear;
  logic        load;

  assign redir     = exc_valid || br_valid;
  assign inst_req  = (state == ST_REQ) && !rst;
  assign inst_addr = pc;

  redirect_latch u_redirect_latch (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .clear        (clear),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .kill         (kill),
    .redir_target (redir_target)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redir) begin
          pc_nxt    = redir_target;
          state_nxt = ST_REQ;
        end else if (!stall) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once the address is accepted the read cannot be withdrawn, so a redirect only kills it.
        if (inst_addr_ok) begin
          state_nxt = ST_WAIT;
          capture   = redir;
        end else if (redir) begin
          pc_nxt = redir_target;
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          clear     = 1'b1;
          state_nxt = ST_REQ;
          if (redir || kill) begin
            pc_nxt = redir_target;
          end else begin
            load   = 1'b1;
            pc_nxt = pc + 32'd4;
            if (stall) state_nxt = ST_IDLE;
          end
        end else begin
          capture = redir;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
      pc    <= RESET_VEC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_inst  <= inst_rdata;
    end else if (redir || !stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule
